spi_burst_ctrl: RTL and testbench

SPI_BURST_CTRL -- requirements
Module: spi_burst_ctrl

---
 rtl/spi_pkg.sv | 16 +
 rtl/sync_fifo.sv | 57 +++++
 rtl/spi_burst_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_spi_burst_ctrl.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and default constants for the SPI burst controller.
package spi_pkg;

  localparam int DEPTH_DEFAULT  = 8;
  localparam int SS_GAP_DEFAULT = 4;

  // Burst sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOAD,
    XFER,
    HOLD
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty flags and a zero-latency head output.
// Pointers carry one extra wrap bit so full and empty are told apart
// without a separate occupancy counter.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  // A pop frees a slot in the same cycle, so a push on a full FIFO is
  // accepted when it coincides with a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // The head has to be visible without a read cycle, so the read is
  // combinational from the storage array.
  assign pop_data = mem[rd_ptr_reg[AW-1:0]];

  // Storage write; no reset needed on the data itself.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  // Pointer update.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/spi_burst_ctrl.sv
// SPI burst controller: sequences slave-select setup, a run of byte
// transfers through an external byte engine, and slave-select hold.
// Optional feature: define SPI_BURST_TIMEOUT_EN to add a 16-bit XFER
// watchdog that aborts a stuck byte and raises sticky timeout_err.
module spi_burst_ctrl
  import spi_pkg::*;
#(
  parameter  int DEPTH  = DEPTH_DEFAULT,
  parameter  int NUM_SS = 2,
  parameter  int SS_GAP = SS_GAP_DEFAULT,
  localparam int SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_len,
  input  logic [SS_W-1:0]   cmd_ss,
  input  logic              tx_wr,
  input  logic [7:0]        tx_data,
  output logic              tx_full,
  input  logic              rx_rd,
  output logic [7:0]        rx_data,
  output logic              rx_empty,
  output logic              busy,
  output logic              done_tick,
  output logic              rx_ovf,
`ifdef SPI_BURST_TIMEOUT_EN
  output logic              timeout_err,
`endif
  output logic [NUM_SS-1:0] ss_n,
  output logic              spi_start,
  output logic [7:0]        spi_din,
  input  logic [7:0]        spi_dout,
  input  logic              spi_done_tick,
  input  logic              spi_ready
);

  localparam int GAP_W = (SS_GAP > 1) ? $clog2(SS_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SS_GAP - 1);

  state_t            state_reg, state_next;
  logic [GAP_W-1:0]  gap_cnt_reg, gap_cnt_next;
  logic [3:0]        byte_cnt_reg, byte_cnt_next;
  logic [3:0]        len_reg, len_next;
  logic [NUM_SS-1:0] ss_n_reg, ss_n_next;
  logic              done_tick_reg, done_tick_next;
  logic              rx_ovf_reg;
  logic [NUM_SS-1:0] sel_n;
  logic              tx_pop, tx_empty;
  logic              rx_push, rx_full;
`ifdef SPI_BURST_TIMEOUT_EN
  logic [15:0]       wdog_reg;
  logic              timeout_err_reg;
  logic              wdog_expired;
`endif

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_wr),
    .push_data (tx_data),
    .pop       (tx_pop),
    .pop_data  (spi_din),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_push),
    .push_data (spi_dout),
    .pop       (rx_rd),
    .pop_data  (rx_data),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  // One-hot-low select decode; an index with no matching line selects none.
  for (genvar gi = 0; gi < NUM_SS; gi++) begin : g_sel
    assign sel_n[gi] = (cmd_ss != SS_W'(gi));
  end

`ifdef SPI_BURST_TIMEOUT_EN
  assign wdog_expired = (wdog_reg == 16'hFFFF);
`endif

  // Next-state, counters and per-cycle strobes.
  always_comb begin
    state_next     = state_reg;
    gap_cnt_next   = gap_cnt_reg;
    byte_cnt_next  = byte_cnt_reg;
    len_next       = len_reg;
    ss_n_next      = ss_n_reg;
    done_tick_next = 1'b0;
    cmd_ready      = 1'b0;
    spi_start      = 1'b0;
    tx_pop         = 1'b0;
    rx_push        = 1'b0;
    unique case (state_reg)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          len_next      = cmd_len;
          ss_n_next     = sel_n;
          gap_cnt_next  = '0;
          byte_cnt_next = '0;
          state_next    = SETUP;
        end
      end
      SETUP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          gap_cnt_next = '0;
          state_next   = LOAD;
        end else begin
          gap_cnt_next = gap_cnt_reg + GAP_W'(1);
        end
      end
      LOAD: begin
        if (spi_ready && !tx_empty) begin
          spi_start  = 1'b1;
          tx_pop     = 1'b1;
          state_next = XFER;
        end
      end
      XFER: begin
        if (spi_done_tick) begin
          rx_push = 1'b1;
          if (byte_cnt_reg == len_reg) begin
            gap_cnt_next = '0;
            state_next   = HOLD;
          end else begin
            byte_cnt_next = byte_cnt_reg + 4'd1;
            state_next    = LOAD;
          end
        end
`ifdef SPI_BURST_TIMEOUT_EN
        else if (wdog_expired) begin
          gap_cnt_next = '0;
          state_next   = HOLD;
        end
`endif
      end
      HOLD: begin
        if (gap_cnt_reg == GAP_LAST) begin
          gap_cnt_next   = '0;
          ss_n_next      = '1;
          done_tick_next = 1'b1;
          state_next     = IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg + GAP_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      gap_cnt_reg   <= '0;
      byte_cnt_reg  <= '0;
      len_reg       <= '0;
      ss_n_reg      <= '1;
      done_tick_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      gap_cnt_reg   <= gap_cnt_next;
      byte_cnt_reg  <= byte_cnt_next;
      len_reg       <= len_next;
      ss_n_reg      <= ss_n_next;
      done_tick_reg <= done_tick_next;
    end
  end

  // Sticky overflow: a received byte is lost only if RX is full and no
  // read frees a slot in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_ovf_reg <= 1'b0;
    end else if (rx_push && rx_full && !rx_rd) begin
      rx_ovf_reg <= 1'b1;
    end
  end

`ifdef SPI_BURST_TIMEOUT_EN
  // Watchdog counts consecutive XFER cycles and latches an abort.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_reg        <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      wdog_reg <= (state_reg == XFER) ? wdog_reg + 16'd1 : 16'd0;
      if (state_reg == XFER && !spi_done_tick && wdog_expired) begin
        timeout_err_reg <= 1'b1;
      end
    end
  end

  assign timeout_err = timeout_err_reg;
`endif

  assign busy      = (state_reg != IDLE);
  assign ss_n      = ss_n_reg;
  assign done_tick = done_tick_reg;
  assign rx_ovf    = rx_ovf_reg;

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Testbench for spi_burst_ctrl with a behavioural byte-engine model and a
// queue-based expectation of received bytes.
module tb_spi_burst_ctrl;

  localparam int DEPTH  = 8;
  localparam int NUM_SS = 2;
  localparam int SS_GAP = 4;
  localparam int SS_W   = 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [3:0]        cmd_len = '0;
  logic [SS_W-1:0]   cmd_ss = '0;
  logic              tx_wr = 1'b0;
  logic [7:0]        tx_data = '0;
  logic              tx_full;
  logic              rx_rd = 1'b0;
  logic [7:0]        rx_data;
  logic              rx_empty;
  logic              busy;
  logic              done_tick;
  logic              rx_ovf;
`ifdef SPI_BURST_TIMEOUT_EN
  logic              timeout_err;
`endif
  logic [NUM_SS-1:0] ss_n;
  logic              spi_start;
  logic [7:0]        spi_din;
  logic [7:0]        spi_dout;
  logic              spi_done_tick;
  logic              spi_ready;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  spi_burst_ctrl #(.DEPTH(DEPTH), .NUM_SS(NUM_SS), .SS_GAP(SS_GAP)) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_len       (cmd_len),
    .cmd_ss        (cmd_ss),
    .tx_wr         (tx_wr),
    .tx_data       (tx_data),
    .tx_full       (tx_full),
    .rx_rd         (rx_rd),
    .rx_data       (rx_data),
    .rx_empty      (rx_empty),
    .busy          (busy),
    .done_tick     (done_tick),
    .rx_ovf        (rx_ovf),
`ifdef SPI_BURST_TIMEOUT_EN
    .timeout_err   (timeout_err),
`endif
    .ss_n          (ss_n),
    .spi_start     (spi_start),
    .spi_din       (spi_din),
    .spi_dout      (spi_dout),
    .spi_done_tick (spi_done_tick),
    .spi_ready     (spi_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Byte engine: takes a start, stays busy 1..4 cycles, returns byte^eng_xor.
  bit         eng_busy = 0;
  bit         eng_hang = 0;
  int         eng_cnt = 0;
  logic [7:0] eng_byte = '0;
  logic [7:0] eng_xor = '0;
  logic       start_seen;
  logic [7:0] din_seen;

  initial begin
    spi_ready = 1'b1;
    spi_done_tick = 1'b0;
    spi_dout = '0;
    forever begin
      @(negedge clk);
      start_seen = spi_start;
      din_seen = spi_din;
      @(posedge clk);
      #1;
      spi_done_tick = 1'b0;
      if (reset) begin
        eng_busy = 0;
        spi_ready = 1'b1;
      end else if (eng_busy) begin
        if (!eng_hang) begin
          if (eng_cnt == 0) begin
            spi_done_tick = 1'b1;
            spi_dout = eng_byte ^ eng_xor;
            eng_busy = 0;
            spi_ready = 1'b1;
          end else begin
            eng_cnt--;
          end
        end
      end else if (start_seen === 1'b1) begin
        eng_busy = 1;
        spi_ready = 1'b0;
        eng_byte = din_seen;
        eng_cnt = $urandom_range(0, 3);
      end
    end
  end

  // Event counters and slave-select watch.
  int                start_cnt = 0;
  int                done_cnt = 0;
  int                multi_low = 0;
  int                ss_bad = 0;
  logic [NUM_SS-1:0] exp_ss_n = '1;

  always @(negedge clk) begin
    if (spi_start === 1'b1) start_cnt <= start_cnt + 1;
    if (done_tick === 1'b1) done_cnt <= done_cnt + 1;
    if (!$onehot0(~ss_n)) multi_low <= multi_low + 1;
    if (busy === 1'b1 && ss_n !== exp_ss_n) ss_bad <= ss_bad + 1;
  end

  // Stimulus helpers; all start and end at a falling edge.
  logic [7:0] tx_q[$];
  int acc_cyc, first_start_cyc, last_sdone_cyc, done_cyc, n_sdone;
  logic ovf_at_sdone;

  task automatic push(input logic [7:0] b);
    tx_wr = 1'b1;
    tx_data = b;
    @(negedge clk);
    tx_wr = 1'b0;
  endtask

  task automatic pop_rx(output logic [7:0] b);
    b = rx_data;
    rx_rd = 1'b1;
    @(negedge clk);
    rx_rd = 1'b0;
  endtask

  task automatic issue_cmd(input logic [3:0] len, input logic [SS_W-1:0] ss);
    cmd_valid = 1'b1;
    cmd_len = len;
    cmd_ss = ss;
    acc_cyc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Wait for done_tick, feeding tx_q whenever the TX buffer can take a byte.
  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    first_start_cyc = -1;
    n_sdone = 0;
    ovf_at_sdone = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      tx_wr = 1'b0;
      if (spi_start === 1'b1 && first_start_cyc < 0) first_start_cyc = cyc;
      if (spi_done_tick === 1'b1) begin
        last_sdone_cyc = cyc;
        n_sdone++;
        ovf_at_sdone = rx_ovf;
      end
      if (done_tick === 1'b1) begin
        done_cyc = cyc;
        ok = 1;
        break;
      end
      if (tx_q.size() > 0 && (!tx_full || spi_start)) begin
        tx_wr = 1'b1;
        tx_data = tx_q.pop_front();
      end
    end
    tx_wr = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    tx_wr = 1'b0;
    rx_rd = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ss_n !== 2'b11) begin errors++; $display("FAIL reset_ss_n: got %b expected 11", ss_n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    checks++; if (tx_full !== 1'b0) begin errors++; $display("FAIL reset_tx_full: got %b expected 0", tx_full); end
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL reset_rx_empty: got %b expected 1", rx_empty); end
    checks++; if (rx_ovf !== 1'b0) begin errors++; $display("FAIL reset_rx_ovf: got %b expected 0", rx_ovf); end
    checks++; if (done_tick !== 1'b0) begin errors++; $display("FAIL reset_done_tick: got %b expected 0", done_tick); end
    checks++; if (spi_start !== 1'b0) begin errors++; $display("FAIL reset_spi_start: got %b expected 0", spi_start); end
    rx_rd = 1'b1;
    @(negedge clk);
    rx_rd = 1'b0;
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL rx_rd_empty: got rx_empty=%b expected 1", rx_empty); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    bit ok;
    logic [7:0] b;
    int s0, d0;
    exp_ss_n = 2'b01;
    eng_xor = 8'h00;
    s0 = start_cnt;
    d0 = done_cnt;
    push(8'hA5);
    push(8'h3C);
    issue_cmd(4'd1, 1'b1);
    wait_done(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_done: got no done_tick expected one within 200 cycles"); end
    checks++; if (first_start_cyc - acc_cyc != SS_GAP + 1) begin errors++; $display("FAIL basic_setup_gap: got %0d expected %0d", first_start_cyc - acc_cyc, SS_GAP + 1); end
    checks++; if (done_cyc - last_sdone_cyc != SS_GAP + 1) begin errors++; $display("FAIL basic_hold_gap: got %0d expected %0d", done_cyc - last_sdone_cyc, SS_GAP + 1); end
    checks++; if (ss_n !== 2'b11) begin errors++; $display("FAIL basic_ss_release: got %b expected 11", ss_n); end
    repeat (2) @(negedge clk);
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt - d0); end
    checks++; if (start_cnt - s0 != 2) begin errors++; $display("FAIL basic_start_count: got %0d expected 2", start_cnt - s0); end
    pop_rx(b);
    checks++; if (b !== 8'hA5) begin errors++; $display("FAIL basic_rx0: got %h expected a5", b); end
    pop_rx(b);
    checks++; if (b !== 8'h3C) begin errors++; $display("FAIL basic_rx1: got %h expected 3c", b); end
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL basic_rx_empty: got %b expected 1", rx_empty); end
    checks++; if (ss_bad != 0) begin errors++; $display("FAIL basic_ss_pattern: got %0d bad cycles expected 0", ss_bad); end
    $display("test_basic done: burst of 2 on ss 1");
  endtask

  task automatic test_tx_stall();
    bit ok;
    logic [7:0] b;
    int s0;
    exp_ss_n = 2'b10;
    eng_xor = 8'h00;
    s0 = start_cnt;
    issue_cmd(4'd0, 1'b0);
    repeat (20) @(negedge clk);
    checks++; if (start_cnt != s0 || spi_start !== 1'b0) begin errors++; $display("FAIL stall_no_start: got %0d starts expected 0", start_cnt - s0); end
    push(8'h55);
    checks++; if (spi_start !== 1'b1) begin errors++; $display("FAIL stall_start_after_push: got %b expected 1", spi_start); end
    checks++; if (spi_din !== 8'h55) begin errors++; $display("FAIL stall_spi_din: got %h expected 55", spi_din); end
    wait_done(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_done: got no done_tick expected one"); end
    pop_rx(b);
    checks++; if (b !== 8'h55) begin errors++; $display("FAIL stall_rx: got %h expected 55", b); end
    $display("test_tx_stall done");
  endtask

  task automatic test_tx_full();
    bit ok;
    logic [7:0] b;
    logic [7:0] vals[9];
    exp_ss_n = 2'b01;
    eng_xor = 8'h00;
    for (int i = 0; i < 9; i++) begin
      vals[i] = 8'($urandom);
      push(vals[i]);
      if (i == 6) begin
        checks++; if (tx_full !== 1'b0) begin errors++; $display("FAIL txfull_at7: got %b expected 0", tx_full); end
      end
      if (i == 7) begin
        checks++; if (tx_full !== 1'b1) begin errors++; $display("FAIL txfull_at8: got %b expected 1", tx_full); end
      end
    end
    issue_cmd(4'd7, 1'b1);
    wait_done(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL txfull_done: got no done_tick expected one"); end
    checks++; if (tx_full !== 1'b0) begin errors++; $display("FAIL txfull_after: got %b expected 0", tx_full); end
    for (int i = 0; i < 8; i++) begin
      pop_rx(b);
      checks++; if (b !== vals[i]) begin errors++; $display("FAIL txfull_rx%0d: got %h expected %h", i, b, vals[i]); end
    end
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL txfull_rx_empty: got %b expected 1", rx_empty); end
    $display("test_tx_full done: ninth push ignored");
  endtask

  task automatic test_overflow();
    bit ok;
    logic [7:0] b;
    logic [7:0] vals[9];
    exp_ss_n = 2'b10;
    eng_xor = 8'h00;
    for (int i = 0; i < 8; i++) begin
      vals[i] = 8'($urandom);
      push(vals[i]);
      if (i == 6) begin
        checks++; if (tx_full !== 1'b0) begin errors++; $display("FAIL ovf_tx_at7: got %b expected 0", tx_full); end
      end
    end
    checks++; if (tx_full !== 1'b1) begin errors++; $display("FAIL ovf_tx_at8: got %b expected 1", tx_full); end
    vals[8] = 8'($urandom);
    tx_q.push_back(vals[8]);
    issue_cmd(4'd8, 1'b0);
    wait_done(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_done: got no done_tick expected one"); end
    checks++; if (n_sdone != 9) begin errors++; $display("FAIL ovf_byte_count: got %0d expected 9", n_sdone); end
    checks++; if (ovf_at_sdone !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0 at 9th tick", ovf_at_sdone); end
    checks++; if (rx_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", rx_ovf); end
    for (int i = 0; i < 8; i++) begin
      pop_rx(b);
      checks++; if (b !== vals[i]) begin errors++; $display("FAIL ovf_rx%0d: got %h expected %h", i, b, vals[i]); end
    end
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL ovf_rx_empty: got %b expected 1", rx_empty); end
    checks++; if (rx_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", rx_ovf); end
    $display("test_overflow done: 9-byte burst into depth 8");
  endtask

  task automatic test_back_to_back();
    bit ok, found;
    logic [7:0] b;
    logic [7:0] v0, v1;
    int s0, d0, starts;
    exp_ss_n = 2'b10;
    eng_xor = 8'h00;
    v0 = 8'($urandom);
    v1 = 8'($urandom);
    push(v0);
    push(v1);
    s0 = start_cnt;
    d0 = done_cnt;
    cmd_valid = 1'b1;
    cmd_len = 4'd0;
    cmd_ss = 1'b0;
    found = 0;
    starts = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (spi_start === 1'b1) starts++;
      if (done_tick === 1'b1) begin found = 1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL b2b_first_done: got no done_tick expected one"); end
    checks++; if (starts != 1) begin errors++; $display("FAIL b2b_starts_before_done: got %0d expected 1", starts); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_at_done: got %b expected 1", cmd_ready); end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_start: got busy=%b expected 1", busy); end
    wait_done(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_second_done: got no done_tick expected one"); end
    repeat (2) @(negedge clk);
    checks++; if (done_cnt - d0 != 2 || start_cnt - s0 != 2) begin errors++; $display("FAIL b2b_counts: got done=%0d start=%0d expected 2 2", done_cnt - d0, start_cnt - s0); end
    pop_rx(b);
    checks++; if (b !== v0) begin errors++; $display("FAIL b2b_rx0: got %h expected %h", b, v0); end
    pop_rx(b);
    checks++; if (b !== v1) begin errors++; $display("FAIL b2b_rx1: got %h expected %h", b, v1); end
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid();
    int n;
    exp_ss_n = 2'b01;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    issue_cmd(4'd2, 1'b1);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (spi_start === 1'b1) n++;
      if (n == 2) break;
    end
    checks++; if (n != 2) begin errors++; $display("FAIL midrst_reach_byte2: got %0d starts expected 2", n); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (ss_n !== 2'b11) begin errors++; $display("FAIL midrst_ss_n: got %b expected 11", ss_n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (tx_full !== 1'b0) begin errors++; $display("FAIL midrst_tx_full: got %b expected 0", tx_full); end
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL midrst_rx_empty: got %b expected 1", rx_empty); end
    checks++; if (rx_ovf !== 1'b0) begin errors++; $display("FAIL midrst_rx_ovf: got %b expected 0", rx_ovf); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    bit ok;
    logic [7:0] b;
    logic [7:0] bytes[$];
    int len, ss, pre, s0, d0;
    for (int t = 0; t < 6; t++) begin
      len = $urandom_range(0, 7);
      ss = $urandom_range(0, NUM_SS - 1);
      pre = $urandom_range(0, len + 1);
      eng_xor = 8'($urandom);
      exp_ss_n = '1;
      exp_ss_n[ss] = 1'b0;
      bytes.delete();
      for (int i = 0; i <= len; i++) bytes.push_back(8'($urandom));
      for (int i = 0; i < pre; i++) push(bytes[i]);
      for (int i = pre; i <= len; i++) tx_q.push_back(bytes[i]);
      s0 = start_cnt;
      d0 = done_cnt;
      issue_cmd(4'(len), SS_W'(ss));
      wait_done(500, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rnd%0d_done: got no done_tick expected one", t); end
      repeat (2) @(negedge clk);
      checks++; if (start_cnt - s0 != len + 1) begin errors++; $display("FAIL rnd%0d_starts: got %0d expected %0d", t, start_cnt - s0, len + 1); end
      checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL rnd%0d_done_count: got %0d expected 1", t, done_cnt - d0); end
      for (int i = 0; i <= len; i++) begin
        pop_rx(b);
        checks++; if (b !== (bytes[i] ^ eng_xor)) begin errors++; $display("FAIL rnd%0d_rx%0d: got %h expected %h", t, i, b, bytes[i] ^ eng_xor); end
      end
      checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL rnd%0d_rx_empty: got %b expected 1", t, rx_empty); end
      $display("burst %0d: len=%0d ss=%0d preload=%0d xor=%h", t, len + 1, ss, pre, eng_xor);
    end
    checks++; if (ss_bad != 0) begin errors++; $display("FAIL ss_pattern: got %0d bad cycles expected 0", ss_bad); end
    checks++; if (multi_low != 0) begin errors++; $display("FAIL ss_onehot: got %0d cycles with several low expected 0", multi_low); end
  endtask

`ifdef SPI_BURST_TIMEOUT_EN
  task automatic test_timeout();
    bit seen;
    int n;
    eng_hang = 1;
    exp_ss_n = 2'b10;
    push(8'h77);
    issue_cmd(4'd0, 1'b0);
    seen = 0;
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk);
      if (timeout_err === 1'b1) begin seen = 1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL timeout_set: got 0 expected timeout_err=1"); end
    n = 0;
    while (ss_n !== 2'b11 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n != SS_GAP) begin errors++; $display("FAIL timeout_hold: got %0d cycles expected %0d", n, SS_GAP); end
    eng_hang = 0;
    do_reset();
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_reset: got %b expected 0", timeout_err); end
    $display("test_timeout done");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_tx_stall();
    test_tx_full();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef SPI_BURST_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
